// File: rtl/icache_responder_if.sv
// rtl/icache_responder_if.sv - fetch-side and memory-side signals of the instruction cache
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache, one word per frame
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_responder #(
  parameter int NFRAMES = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  icache_responder_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);
  localparam int IDXW = $clog2(NFRAMES);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NFRAMES-1:0] r_valid;
  logic [TAGW-1:0]   r_tag  [NFRAMES];
  logic [31:0]       r_data [NFRAMES];
  logic [29:0]       r_fill_word;

  logic [IDXW-1:0]   w_idx;
  logic [IDXW-1:0]   w_fill_idx;
  logic [TAGW-1:0]   w_tag;
  logic [TAGW-1:0]   w_fill_tag;
  logic              w_lookup_hit;
  logic              w_ihit;
  logic              w_start;
  logic              w_fill;
  logic              w_unused_low;

  assign w_idx        = bus.imemaddr[2+IDXW-1:2];
  assign w_tag        = bus.imemaddr[31:2+IDXW];
  assign w_fill_idx   = r_fill_word[IDXW-1:0];
  assign w_fill_tag   = r_fill_word[29:IDXW];
  assign w_unused_low = ^bus.imemaddr[1:0];

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_fill       = 1'b0;
    w_ihit       = 1'b0;
    w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    case (r_state)
      IDLE: begin
        w_ihit = bus.imemREN && w_lookup_hit;
        if (bus.imemREN && !w_lookup_hit) begin
          w_next  = FETCH;
          w_start = 1'b1;
        end
      end
      FETCH: begin
        // The fill lands even if the datapath has redirected meanwhile.
        if (!bus.iwait) begin
          w_next = IDLE;
          w_fill = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.ihit     = w_ihit;
  assign bus.imemload = w_ihit ? r_data[w_idx] : 32'h0;
  assign bus.iREN     = (r_state == FETCH);
  assign bus.iaddr    = {r_fill_word, 2'b00};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_fill_word <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_fill_word <= bus.imemaddr[31:2];
      if (w_fill)  r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (nRST && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (w_ihit)  hit_count  <= hit_count + 32'h1;
      if (w_start) miss_count <= miss_count + 32'h1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - scoreboard bench for icache_responder
module tb_icache_responder;
  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  icache_responder_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  icache_responder #(.NFRAMES(16)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );
`else
  icache_responder #(.NFRAMES(16)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one fetch and follow it to its hit; misses are expected to request
  // the aligned address, stall for waits cycles, then hit the cycle after fill.
  task automatic fetch(input logic [31:0] addr, input int waits, input logic [31:0] load,
                       input bit exp_miss, input logic [31:0] exp_data);
    int  fcyc;
    bit  done;
    int  exp_c;
    fcyc  = 0;
    done  = 0;
    exp_c = exp_miss ? waits + 2 : 0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    bus.iload    = 32'hDEADBEEF;
    if (exp_miss) q_addr.push_back({addr[31:2], 2'b00});
    q_data.push_back(exp_data);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (bus.ihit) begin
        total++;
        if (bus.imemload !== q_data[0])
          $display("FAIL imemload addr=%h got=%h exp=%h", addr, bus.imemload, q_data[0]);
        else ;
        if (bus.imemload !== q_data[0]) bad++;
        void'(q_data.pop_front());
        total++;
        if (c != exp_c) begin
          bad++;
          $display("FAIL hit_latency addr=%h got=%0d exp=%0d", addr, c, exp_c);
        end
        total++;
        if (bus.iREN !== 1'b0 || q_addr.size() != 0) begin
          bad++;
          $display("FAIL hit_state addr=%h iREN=%b pending_fills=%0d exp iREN=0 pending=0",
                   addr, bus.iREN, q_addr.size());
        end
        done = 1;
      end else if (bus.iREN) begin
        fcyc++;
        total++;
        if (q_addr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_fill addr=%h iaddr=%h exp no fetch", addr, bus.iaddr);
        end else if (bus.iaddr !== q_addr[0]) begin
          bad++;
          $display("FAIL iaddr got=%h exp=%h", bus.iaddr, q_addr[0]);
        end
        if (fcyc <= waits) begin
          bus.iwait = 1'b1;
          bus.iload = 32'hDEADBEEF;
        end else begin
          bus.iwait = 1'b0;
          bus.iload = load;
          if (q_addr.size() != 0) void'(q_addr.pop_front());
        end
      end
      step();
      bus.iwait = 1'b1;
      bus.iload = 32'hDEADBEEF;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout addr=%h got no ihit exp ihit", addr);
      q_addr.delete();
      q_data.delete();
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    step();
    step();
    nRST = 1'b1;
    @(negedge CLK);
    total++;
    if ({bus.ihit, bus.iREN} !== 2'b00 || bus.imemload !== 32'h0 || bus.iaddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs ihit=%b iREN=%b imemload=%h iaddr=%h exp all 0",
               bus.ihit, bus.iREN, bus.imemload, bus.iaddr);
    end
    step();
  endtask

  task automatic test_cold_miss();
    fetch(32'h0, 3, 32'h3C010004, 1'b1, 32'h3C010004);
  endtask

  task automatic test_hit();
    fetch(32'h0, 0, 32'h0, 1'b0, 32'h3C010004);
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
      bad++;
      $display("FAIL stats hit=%0d miss=%0d exp hit=2 miss=1", hit_count, miss_count);
    end
`endif
    fetch(32'h3, 0, 32'h0, 1'b0, 32'h3C010004);
  endtask

  task automatic test_conflict();
    fetch(32'h40, 1, 32'h11110040, 1'b1, 32'h11110040);
    fetch(32'h0, 2, 32'h22220000, 1'b1, 32'h22220000);
    fetch(32'h0, 0, 32'h0, 1'b0, 32'h22220000);
  endtask

  task automatic test_redirect();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h08;
    @(negedge CLK);
    step();
    @(negedge CLK);
    total++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h08) begin
      bad++;
      $display("FAIL redirect_req iREN=%b iaddr=%h exp iREN=1 iaddr=00000008", bus.iREN, bus.iaddr);
    end
    step();
    bus.imemaddr = 32'h10;
    @(negedge CLK);
    total++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h08 || bus.ihit !== 1'b0) begin
      bad++;
      $display("FAIL redirect_hold iREN=%b iaddr=%h ihit=%b exp 1 00000008 0",
               bus.iREN, bus.iaddr, bus.ihit);
    end
    bus.iwait = 1'b0;
    bus.iload = 32'h33330008;
    step();
    bus.iwait = 1'b1;
    fetch(32'h10, 1, 32'h44440010, 1'b1, 32'h44440010);
    fetch(32'h08, 0, 32'h0, 1'b0, 32'h33330008);
  endtask

  task automatic test_reset_mid_fill();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h20;
    @(negedge CLK);
    step();
    @(negedge CLK);
    total++;
    if (bus.iREN !== 1'b1) begin
      bad++;
      $display("FAIL mid_fill_req iREN=%b exp 1", bus.iREN);
    end
    bus.iwait = 1'b0;
    bus.iload = 32'h55550020;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    bus.iwait = 1'b1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.iREN !== 1'b0 || bus.ihit !== 1'b0 || bus.iaddr !== 32'h0) begin
      bad++;
      $display("FAIL post_reset iREN=%b ihit=%b iaddr=%h exp 0 0 00000000",
               bus.iREN, bus.ihit, bus.iaddr);
    end
    step();
    fetch(32'h0, 0, 32'h66660000, 1'b1, 32'h66660000);
    fetch(32'h20, 0, 32'h77770020, 1'b1, 32'h77770020);
  endtask

  task automatic test_back_to_back();
    fetch(32'h0, 0, 32'h0, 1'b0, 32'h66660000);
    fetch(32'h20, 0, 32'h0, 1'b0, 32'h77770020);
    fetch(32'h0, 0, 32'h0, 1'b0, 32'h66660000);
    fetch(32'h22, 0, 32'h0, 1'b0, 32'h77770020);
  endtask

  task automatic test_no_request();
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h100;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      total++;
      if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0 || bus.imemload !== 32'h0) begin
        bad++;
        $display("FAIL no_request cyc=%0d ihit=%b iREN=%b imemload=%h exp 0 0 0",
                 i, bus.ihit, bus.iREN, bus.imemload);
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_redirect();
    test_reset_mid_fill();
    test_back_to_back();
    test_no_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
